// File: rtl/mfp_ahb_sevenseg.sv
// rtl/mfp_ahb_sevenseg.sv - AHB-Lite slave driving an 8-digit multiplexed seven-segment display
//
// Purpose:
//   Four software-visible registers (digit enables, high/low digit nibbles,
//   decimal points) behind a zero-wait-state AHB-Lite slave, plus a refresh
//   engine that scans one digit per REFRESH_DIV clocks and drives registered,
//   active-low segment and anode outputs.
//
// Ports:
//   HCLK            clock, all state on rising edge
//   HRESETn         asynchronous active-low reset
//   HSEL            slave select
//   HADDR[31:0]     address, only [3:2] decoded
//   HTRANS[1:0]     transfer type, HTRANS[1]=1 marks a real transfer
//   HWRITE          1 = write
//   HWDATA[31:0]    write data (data phase)
//   HRDATA[31:0]    read data (data phase), 0 outside a read data phase
//   SEG_CA..SEG_CG  segments a..g, active-low
//   SEG_DP          decimal point, active-low
//   SEG_AN[7:0]     digit anodes, active-low, one-hot-low or all-high
module mfp_ahb_sevenseg #(
  parameter int REFRESH_DIV = 12500
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        SEG_CA,
  output logic        SEG_CB,
  output logic        SEG_CC,
  output logic        SEG_CD,
  output logic        SEG_CE,
  output logic        SEG_CF,
  output logic        SEG_CG,
  output logic        SEG_DP,
  output logic [7:0]  SEG_AN
);

  // A one-clock slot still needs a 1-bit prescaler so the logic stays legal.
  localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  // Register indices on HADDR[3:2]
  localparam logic [1:0] IDX_EN  = 2'd0;
  localparam logic [1:0] IDX_DHI = 2'd1;
  localparam logic [1:0] IDX_DLO = 2'd2;
  localparam logic [1:0] IDX_DP  = 2'd3;

  // Address-phase capture
  logic [1:0]    addr_idx_q, addr_idx_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;

  // Software registers
  logic [7:0]    en_q, en_d;
  logic [15:0]   dhi_q, dhi_d;
  logic [15:0]   dlo_q, dlo_d;
  logic [7:0]    dp_q, dp_d;

  // Refresh engine
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;

  // Registered display outputs, {a,b,c,d,e,f,g} active-low
  logic [6:0]    seg_q, seg_d;
  logic          dp_out_q, dp_out_d;
  logic [7:0]    an_q, an_d;

  logic          xfer;
  logic [31:0]   rdata;
  logic [15:0]   disp_word;
  logic [3:0]    nibble;
  logic [6:0]    lit;

  // Address bits outside [3:2], HTRANS[0] and HWDATA[31:16] carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

  // Lit-segment pattern {a,b,c,d,e,f,g}, 1 = segment on.
  function automatic logic [6:0] hex_lit(input logic [3:0] v);
    logic [6:0] p;
    unique case (v)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      4'hF: p = 7'b1000111;
    endcase
    return p;
  endfunction

  // Bus address phase and data-phase register update
  always_comb begin
    xfer       = HSEL & HTRANS[1];
    addr_idx_d = xfer ? HADDR[3:2] : addr_idx_q;
    wr_d       = xfer & HWRITE;
    rd_d       = xfer & ~HWRITE;

    en_d  = en_q;
    dhi_d = dhi_q;
    dlo_d = dlo_q;
    dp_d  = dp_q;
    if (wr_q) begin
      unique case (addr_idx_q)
        IDX_EN:  en_d  = HWDATA[7:0];
        IDX_DHI: dhi_d = HWDATA[15:0];
        IDX_DLO: dlo_d = HWDATA[15:0];
        IDX_DP:  dp_d  = HWDATA[7:0];
      endcase
    end
  end

  // Read mux. A read issued right after a write sees the new value because the
  // write lands on the edge that starts the read's data phase.
  always_comb begin
    rdata = 32'h0;
    unique case (addr_idx_q)
      IDX_EN:  rdata = {24'h0, en_q};
      IDX_DHI: rdata = {16'h0, dhi_q};
      IDX_DLO: rdata = {16'h0, dlo_q};
      IDX_DP:  rdata = {24'h0, dp_q};
    endcase
    HRDATA = rd_q ? rdata : 32'h0;
  end

  // Refresh scan and output formation. Outputs are built from the live
  // registers every cycle, so a write to the digit on display shows up one
  // clock later rather than at the next slot.
  always_comb begin
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      digit_d = digit_q;
    end

    disp_word = digit_q[2] ? dhi_q : dlo_q;
    nibble    = disp_word[{digit_q[1:0], 2'b00} +: 4];
    lit       = hex_lit(nibble);

    if (en_q[digit_q]) begin
      an_d     = ~(8'h01 << digit_q);
      seg_d    = ~lit;
      dp_out_d = ~dp_q[digit_q];
    end else begin
      an_d     = 8'hFF;
      seg_d    = 7'h7F;
      dp_out_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_idx_q <= 2'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      en_q       <= 8'h00;
      dhi_q      <= 16'h0000;
      dlo_q      <= 16'h0000;
      dp_q       <= 8'h00;
      presc_q    <= '0;
      digit_q    <= 3'd0;
      seg_q      <= 7'h7F;
      dp_out_q   <= 1'b1;
      an_q       <= 8'hFF;
    end else begin
      addr_idx_q <= addr_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      en_q       <= en_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      dp_q       <= dp_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      seg_q      <= seg_d;
      dp_out_q   <= dp_out_d;
      an_q       <= an_d;
    end
  end

  assign {SEG_CA, SEG_CB, SEG_CC, SEG_CD, SEG_CE, SEG_CF, SEG_CG} = seg_q;
  assign SEG_DP = dp_out_q;
  assign SEG_AN = an_q;

endmodule

// File: tb/tb_mfp_ahb_sevenseg.sv
// tb/tb_mfp_ahb_sevenseg.sv - scoreboard bench for the seven-segment AHB-Lite slave
module tb_mfp_ahb_sevenseg;

  localparam int R = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'h0;
  logic [31:0] HRDATA;
  logic        SEG_CA, SEG_CB, SEG_CC, SEG_CD, SEG_CE, SEG_CF, SEG_CG, SEG_DP;
  logic [7:0]  SEG_AN;

  mfp_ahb_sevenseg #(.REFRESH_DIV(R)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .SEG_CA(SEG_CA), .SEG_CB(SEG_CB), .SEG_CC(SEG_CC), .SEG_CD(SEG_CD),
    .SEG_CE(SEG_CE), .SEG_CF(SEG_CF), .SEG_CG(SEG_CG), .SEG_DP(SEG_DP),
    .SEG_AN(SEG_AN)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  // Reference register file, updated when a write's data phase is driven
  logic [7:0]  m_en = 8'h0, m_dp = 8'h0;
  logic [15:0] m_dhi = 16'h0, m_dlo = 16'h0;

  // Monitor's view of the state after the previous clock edge
  logic [7:0]  s_en = 8'h0, s_dp = 8'h0;
  logic [15:0] s_dhi = 16'h0, s_dlo = 16'h0;
  int          n_edges = 0;

  logic        pend_wr = 1'b0;
  logic [1:0]  pend_idx = 2'd0;
  logic [31:0] pend_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Segment s (0=a .. 6=g) is lit for digit d when bit d of its mask is set.
  function automatic logic seg_on(input int s, input logic [3:0] d);
    logic [15:0] m;
    case (s)
      0: m = 16'hD7ED;
      1: m = 16'h279F;
      2: m = 16'h2FFB;
      3: m = 16'h7B6D;
      4: m = 16'hFD45;
      5: m = 16'hDF71;
      6: m = 16'hEF7C;
      default: m = 16'h0;
    endcase
    return m[d];
  endfunction

  // Expected {SEG_AN, a..g, DP} while digit slot 'slot' is shown.
  function automatic logic [15:0] exp_disp(input int slot, input logic [7:0] en, input logic [7:0] dp,
                                           input logic [15:0] dhi, input logic [15:0] dlo);
    logic [31:0] digits;
    logic [3:0]  nib;
    logic [6:0]  segs;
    logic [7:0]  an;
    if (!en[slot]) return 16'hFFFF;
    digits = {dhi, dlo};
    nib = digits[slot*4 +: 4];
    for (int s = 0; s < 7; s++) segs[6-s] = ~seg_on(s, nib);
    an = ~(8'h01 << slot);
    return {an, segs, ~dp[slot]};
  endfunction

  function automatic void mwrite(input logic [1:0] idx, input logic [31:0] d);
    case (idx)
      2'd0: m_en  = d[7:0];
      2'd1: m_dhi = d[15:0];
      2'd2: m_dlo = d[15:0];
      default: m_dp = d[7:0];
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [1:0] idx);
    case (idx)
      2'd0: return {24'h0, m_en};
      2'd1: return {16'h0, m_dhi};
      2'd2: return {16'h0, m_dlo};
      default: return {24'h0, m_dp};
    endcase
  endfunction

  function automatic logic [15:0] act_disp();
    return {SEG_AN, SEG_CA, SEG_CB, SEG_CC, SEG_CD, SEG_CE, SEG_CF, SEG_CG, SEG_DP};
  endfunction

  // One bus clock: data phase of the previous transfer, address phase of a new one.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge HCLK);
    HWDATA = pend_data;
    if (pend_wr) mwrite(pend_idx, pend_data);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr;
    pend_wr   = sel & trans[1] & wr;
    pend_idx  = addr[3:2];
    pend_data = wdata;
    if (sel && trans[1] && !wr) exp_q.push_back(mread(addr[3:2]));
  endtask

  function automatic logic [31:0] reg_addr(input logic [1:0] idx);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = idx;
    return a;
  endfunction

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d);
    bus_cycle(1'b1, 2'b10, 1'b1, reg_addr(idx), d);
  endtask

  task automatic rd_reg(input logic [1:0] idx);
    bus_cycle(1'b1, 2'b10, 1'b0, reg_addr(idx), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 2'b00, 1'b0, $urandom, $urandom);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge HCLK);
    HWDATA  = pend_data;
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    pend_wr = 1'b0;
    m_en = 8'h0; m_dp = 8'h0; m_dhi = 16'h0; m_dlo = 16'h0;
    exp_q.delete();
    #1;
    check("reset_blank_now", {16'h0, act_disp()}, 32'h0000FFFF);
    check("reset_hrdata_now", HRDATA, 32'h0);
    repeat (cycles) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  // Monitor: compares display and read data against the scoreboard each cycle.
  always @(posedge HCLK) begin
    #1;
    if (!HRESETn) begin
      n_edges = 0;
      s_en = 8'h0; s_dp = 8'h0; s_dhi = 16'h0; s_dlo = 16'h0;
      check("display_in_reset", {16'h0, act_disp()}, 32'h0000FFFF);
      check("hrdata_in_reset", HRDATA, 32'h0);
    end else begin
      n_edges++;
      check("display", {16'h0, act_disp()},
            {16'h0, exp_disp(((n_edges - 1) / R) % 8, s_en, s_dp, s_dhi, s_dlo)});
      if (HSEL && HTRANS[1] && !HWRITE) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL read_unexpected @%0t: got %h expected no read", $time, HRDATA);
        end else begin
          check("read_data", HRDATA, exp_q.pop_front());
        end
      end else begin
        check("hrdata_idle", HRDATA, 32'h0);
      end
      s_en = m_en; s_dp = m_dp; s_dhi = m_dhi; s_dlo = m_dlo;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int guard;
    logic [31:0] r;

    apply_reset(3);
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    idle(2);

    wr_reg(2'd0, 32'h0000_0001);
    wr_reg(2'd2, 32'h0000_0008);
    idle(40);

    wr_reg(2'd0, 32'h0000_00FF);
    wr_reg(2'd1, 32'h0000_FEDC);
    wr_reg(2'd2, 32'h0000_BA98);
    wr_reg(2'd3, 32'h0000_0080);
    idle(72);

    wr_reg(2'd2, 32'h0000_1234);
    rd_reg(2'd2);
    bus_cycle(1'b1, 2'b00, 1'b1, 32'h0000_0000, 32'h0000_0000);
    bus_cycle(1'b1, 2'b01, 1'b1, 32'h0000_0000, 32'h0000_0000);
    bus_cycle(1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0000_0000);
    rd_reg(2'd0);
    wr_reg(2'd2, 32'hFFFF_5555);
    rd_reg(2'd2);
    wr_reg(2'd0, 32'hFFFF_FFFF);
    idle(2);

    guard = 0;
    while (!((((n_edges / R) % 8) == 3) && ((n_edges % R) == 1)) && guard < 200) begin
      @(negedge HCLK);
      guard++;
    end
    check("slot3_reached", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    wr_reg(2'd3, 32'h0000_00FF);
    apply_reset(2);
    idle(3);
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    wr_reg(2'd0, 32'h0000_00FF);
    wr_reg(2'd1, 32'h0000_7654);
    wr_reg(2'd2, 32'h0000_3210);
    wr_reg(2'd3, 32'h0000_0001);
    idle(40);

    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      bus_cycle(r[0] | r[1], r[3:2], r[4], $urandom, $urandom);
    end
    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_sevenseg.md
MFP_AHB_SEVENSEG -- requirements
Module: mfp_ahb_sevenseg

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 12500: HCLK cycles per digit slot (4 kHz digit rate, 500 Hz frame at 50 MHz).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port HCLK, input, 1: bus and block clock; all state on rising edge.
REQ-004 Port HRESETn, input, 1: asynchronous active-low reset.
REQ-005 Port HSEL, input, 1: slave select from the AHB-Lite decoder.
REQ-006 Port HADDR, input, 32: address; only bits [3:2] decoded, all others ignored.
REQ-007 Port HTRANS, input, 2: transfer type; a transfer is valid only when HTRANS[1]=1.
REQ-008 Port HWRITE, input, 1: 1 = write.
REQ-009 Port HWDATA, input, 32: write data, sampled in the data phase.
REQ-010 Port HRDATA, output, 32: read data, valid in the data phase.
REQ-011 Port SEG_CA..SEG_CG, output, 1 each: segments a-g, active-low.
REQ-012 Port SEG_DP, output, 1: decimal point, active-low.
REQ-013 Port SEG_AN, output, 8: digit anodes, active-low, one-hot-low or all-high.

Function
REQ-014 Register map on HADDR[3:2]: 0 EN[7:0] (digit enables); 1 DHI[15:0] (digits 7..4, nibble 3 = digit 7); 2 DLO[15:0] (digits 3..0, nibble 0 = digit 0); 3 DP[7:0] (decimal points, 1 = lit).
REQ-015 Unused upper register bits SHALL read 0 and SHALL ignore writes.
REQ-016 Address phase: when HSEL & HTRANS[1], SHALL register the address index, the write-valid flag (HWRITE) and the read-valid flag (~HWRITE).
REQ-017 Data phase: a registered write-valid SHALL load HWDATA into the selected register at the clock edge ending the data phase.
REQ-018 HSIZE SHALL be ignored: every write updates the full register width; software uses word stores only.
REQ-019 HRDATA SHALL be driven combinationally from the registered address index; it SHALL be 0 when the registered read-valid flag is 0.
REQ-020 Read of a register in the cycle after a write to that register SHALL return the newly written value.
REQ-021 Back-to-back writes on every cycle SHALL all take effect, in order; no wait states; the block has no HREADY output.
REQ-022 HTRANS IDLE/BUSY, or HSEL=0, SHALL cause no register change.
REQ-023 Prescaler: counter of width clog2(REFRESH_DIV), counting 0..REFRESH_DIV-1 and then wrapping to 0.
REQ-024 Digit index: 3-bit counter that increments when the prescaler wraps; it wraps from 7 to 0.
REQ-025 Hex decode SHALL follow standard patterns for 0-F (e.g. 0 lights a-f; 8 lights all; F lights a,e,f,g).
REQ-026 SEG_*, SEG_DP and SEG_AN SHALL be registered: they reflect the digit index, EN, DP and the digit nibble sampled one HCLK after those values change.
REQ-027 If EN[idx]=1: SEG_AN[idx]=0, all other SEG_AN bits =1, segments per the nibble, SEG_DP=~DP[idx].
REQ-028 If EN[idx]=0: SEG_AN=8'hFF and all segments and SEG_DP =1 (blank) for that slot.
REQ-029 A register write to the currently displayed digit SHALL appear on the outputs one HCLK after the register updates, without waiting for the next slot.

Reset
REQ-030 HRESETn low SHALL immediately clear: EN, DHI, DLO, DP, prescaler, digit index and the address-phase registers; SEG_AN=8'hFF; SEG_CA..SEG_CG=1; SEG_DP=1; HRDATA=0.
REQ-031 Reset asserted mid-transfer SHALL discard the pending write; after release, refresh SHALL restart at digit 0, prescaler 0.

Verification
REQ-032 Reset -> SEG_AN=FF, all segments 1, HRDATA=0; reads of all 4 registers return 0.
REQ-033 Write EN=0x01 and DLO=0x0008, with REFRESH_DIV=4 -> during slot 0: SEG_AN=FE, all segments and SEG_DP low except SEG_DP=1; during slots 1..7: SEG_AN=FF.
REQ-034 Write EN=FF, DHI=0xFEDC, DLO=0xBA98, DP=0x80 -> digits 7..0 show F,E,D,C,B,A,9,8, slots one REFRESH_DIV apart; SEG_DP=0 only while SEG_AN=7F; index wraps 7 to 0.
REQ-035 Write DLO=0x1234 followed immediately by a read of DLO -> read returns 0x00001234; a write to address 0x0 with HTRANS=IDLE leaves EN unchanged.
REQ-036 Write DLO with 0xFFFF5555 -> read returns 0x00005555; write EN=FF, then pulse HRESETn low mid-slot 3 -> outputs blank at once; after release, refresh resumes at digit 0.
